// File: rtl/rv_timer_cmp_sched_if.sv
// Bus bundle for the timer compare scheduler: tick/mtime/compare inputs
// toward the scheduler and the per-channel expired status coming back.
interface rv_timer_cmp_sched_if #(
    parameter int N_CMP = 4
);
    logic                  tick_i;
    logic [63:0]           mtime_i;
    logic [64*N_CMP-1:0]   mtimecmp_i;
    logic [N_CMP-1:0]      cmp_update_i;
    logic [N_CMP-1:0]      cmp_en_i;
    logic [N_CMP-1:0]      expired_o;
    logic [N_CMP-1:0]      expired_pulse_o;
    logic                  busy_o;

    modport master (
        output tick_i, mtime_i, mtimecmp_i, cmp_update_i, cmp_en_i,
        input  expired_o, expired_pulse_o, busy_o
    );

    modport slave (
        input  tick_i, mtime_i, mtimecmp_i, cmp_update_i, cmp_en_i,
        output expired_o, expired_pulse_o, busy_o
    );
endinterface

// File: rtl/rv_timer_cmp_sched.sv
// Timer compare scheduler: N_CMP compare channels share a single 64-bit
// comparator. Each tick (or compare write) triggers a scan that checks one
// channel per cycle against a snapshot of mtime, setting sticky expired
// flags. Events arriving mid-scan coalesce into one pending rescan.
module rv_timer_cmp_sched #(
    parameter int N_CMP = 4,
    parameter int IDX_W = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rv_timer_cmp_sched_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_s;
    logic [63:0]        snap_r;
    logic [63:0]        snap_s;
    logic               pending_r;
    logic               pending_s;
    logic [N_CMP-1:0]   expired_r;
    logic [N_CMP-1:0]   expired_s;
    logic [N_CMP-1:0]   pulse_r;
    logic [N_CMP-1:0]   pulse_s;
    logic [N_CMP-1:0]   set_s;
    logic               busy_r;
    logic               busy_s;

    logic [63:0]        cmp_arr_s [N_CMP];
    logic [63:0]        cmp_sel_s;
    logic               en_sel_s;
    logic               hit_s;
    logic               last_s;
    logic               any_evt_s;

    // Split the flat compare bus into per-channel words.
    always_comb begin
        for (int k = 0; k < N_CMP; k++) begin
            cmp_arr_s[k] = bus.mtimecmp_i[64*k +: 64];
        end
    end

    // The single shared comparator; compare values are taken live, mtime from the snapshot.
    always_comb begin
        cmp_sel_s = cmp_arr_s[idx_r];
        en_sel_s  = bus.cmp_en_i[idx_r];
        hit_s     = (snap_r >= cmp_sel_s);
        last_s    = (idx_r == IDX_W'(N_CMP - 1));
        any_evt_s = bus.tick_i | (|bus.cmp_update_i);
    end

    // Scan FSM next-state: start/restart loads a fresh snapshot, otherwise events coalesce into pending.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        snap_s    = snap_r;
        pending_s = pending_r;
        case (state_r)
            IDLE: begin
                if (bus.tick_i || pending_r) begin
                    state_s   = SCAN;
                    snap_s    = bus.mtime_i;
                    idx_s     = '0;
                    pending_s = 1'b0;
                end else begin
                    pending_s = pending_r | any_evt_s;
                end
            end
            SCAN: begin
                if (last_s) begin
                    if (pending_r || any_evt_s) begin
                        snap_s    = bus.mtime_i;
                        idx_s     = '0;
                        pending_s = 1'b0;
                    end else begin
                        state_s   = IDLE;
                    end
                end else begin
                    idx_s     = idx_r + IDX_W'(1);
                    pending_s = pending_r | any_evt_s;
                end
            end
            default: begin
                state_s   = IDLE;
                idx_s     = '0;
                pending_s = 1'b0;
            end
        endcase
    end

    // Expired flags: set from the scanned channel, a same-cycle compare write wins and clears.
    always_comb begin
        set_s = '0;
        for (int k = 0; k < N_CMP; k++) begin
            set_s[k] = (state_r == SCAN) && (idx_r == IDX_W'(k)) && hit_s && en_sel_s;
        end
        expired_s = (expired_r | set_s) & ~bus.cmp_update_i;
        pulse_s   = expired_s & ~expired_r;
        busy_s    = (state_s == SCAN);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            snap_r    <= 64'd0;
            pending_r <= 1'b0;
            expired_r <= '0;
            pulse_r   <= '0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            snap_r    <= snap_s;
            pending_r <= pending_s;
            expired_r <= expired_s;
            pulse_r   <= pulse_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.expired_o       = expired_r;
    assign bus.expired_pulse_o = pulse_r;
    assign bus.busy_o          = busy_r;

endmodule

// File: doc/rv_timer_cmp_sched.md
RV_TIMER_CMP_SCHED -- requirements
Module: rv_timer_cmp_sched

Interface
REQ-001 SHALL have parameter N_CMP, default 4, meaning the number of compare channels sharing one 64-bit comparator (range 1..16).
REQ-002 SHALL have parameter IDX_W, default 2, meaning the channel index width (= clog2(N_CMP), minimum 1).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst_i, input, 1, the reset: asynchronous and active-high.
REQ-005 SHALL have port tick_i, input, 1, a one-cycle pulse indicating that mtime has advanced.
REQ-006 SHALL have port mtime_i, input, 64, the current mtime value.
REQ-007 SHALL have port mtimecmp_i, input, 64*N_CMP, the compare values; channel k is bits [64k+63:64k].
REQ-008 SHALL have port cmp_update_i, input, N_CMP, one-cycle pulses indicating a software write to compare channel k.
REQ-009 SHALL have port cmp_en_i, input, N_CMP, per-channel evaluation enable.
REQ-010 SHALL have port expired_o, output, N_CMP, a sticky expired flag per channel.
REQ-011 SHALL have port expired_pulse_o, output, N_CMP, a one-cycle pulse on each 0->1 transition of expired_o[k].
REQ-012 SHALL have port busy_o, output, 1, asserted while the scan FSM is in SCAN.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SCAN, with an IDX_W-bit scan index and a 64-bit mtime snapshot register.
REQ-014 SHALL, in IDLE, when tick_i=1 or the pending flag is 1, go to SCAN at the next edge, load snapshot<=mtime_i, set idx<=0 and clear pending.
REQ-015 SHALL, in SCAN, evaluate exactly one channel per cycle (channel idx) using one unsigned 64-bit comparison: hit = snapshot >= mtimecmp_i[idx].
REQ-016 SHALL set expired_o[idx] at the end of the cycle when hit=1, cmp_en_i[idx]=1, and no cmp_update_i[idx] occurs that cycle.
REQ-017 SHALL leave a disabled channel unchanged while still spending its cycle; every scan lasts exactly N_CMP cycles.
REQ-018 SHALL, at idx=N_CMP-1, go to IDLE if pending=0 (and no tick_i/update that cycle); otherwise restart the scan at idx=0 with a fresh snapshot and clear pending.
REQ-019 SHALL set pending when tick_i=1 or any cmp_update_i bit=1 in a cycle that does not itself start a scan.
REQ-020 SHALL clear expired_o[k] at the next edge after cmp_update_i[k]=1 and set pending; an update beats a same-cycle set on the same channel.
REQ-021 SHALL keep expired_o[k] otherwise sticky: cleared only by reset or cmp_update_i[k]; a falling mtime or cmp_en_i does not clear it.
REQ-022 SHALL register expired_pulse_o[k] high for exactly the one cycle in which expired_o[k] first reads 1.
REQ-023 SHALL apply this latency: tick_i in cycle 0 -> busy_o high in cycles 1..N_CMP -> expired_o[k] visible from cycle 2+k.
REQ-024 SHALL treat back-to-back ticks during a scan as a single pending flag (coalesced) and drop none of them.
REQ-025 SHALL compare mtimecmp_i live each cycle; only mtime is snapshotted.

Reset
REQ-026 SHALL, while rst_i=1, immediately force state=IDLE, idx=0, snapshot=0, pending=0, expired_o=0, expired_pulse_o=0 and busy_o=0, including mid-scan.
REQ-027 SHALL, in the first cycle after rst_i falls, react to tick_i normally with no spurious pulses.

Verification (N_CMP=4)
REQ-028 SHALL verify: mtime=100, cmp={50,100,101,0xFFFF_FFFF_FFFF_FFFF}, all enabled, tick at cycle 0 -> expired 0b0011, pulse[0] at cycle 2, pulse[1] at cycle 3, busy cycles 1-4.
REQ-029 SHALL verify: cmp_en=0b1110 with the case above -> expired=0b0010, and busy still 4 cycles.
REQ-030 SHALL verify: tick at cycle 0, tick again at cycle 2 with mtime=101 -> second scan in cycles 5-8 and expired[2] set at cycle 8.
REQ-031 SHALL verify: ch1 expired, cmp_update[1] with cmp=200 -> expired[1]=0 next cycle, rescan leaves it 0, and no pulse.
REQ-032 SHALL verify: cmp_update[0] coincides with a scan hit on ch0 -> expired[0] stays 0 and a rescan follows.
REQ-033 SHALL verify: rst_i asserted at cycle 2 of a scan -> all outputs 0 asynchronously, and FSM in IDLE after release.
